// File: rtl/scmp_bus_pkg.sv
// Shared types and constants for the SC/MP bus interface stage.
package scmp_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CPU_AW = 12;

   // Bit positions of the status flags carried on D_o during the address phase
   localparam int unsigned FLG_H = 7;
   localparam int unsigned FLG_D = 6;
   localparam int unsigned FLG_I = 5;
   localparam int unsigned FLG_R = 4;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      REQ,
      DONE
   } bus_state_t;

   // Counter width able to hold the value t (t >= 1)
   function automatic int unsigned tmr_width(input int unsigned t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/scmp_bus_if_if.sv
// Synchronous memory port: request/ack handshake with address and data.
interface scmp_bus_if_if;
   import scmp_bus_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              req;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, wdata, we, req, input ack, rdata);
   modport slave  (input addr, wdata, we, req, output ack, rdata);
endinterface

// File: rtl/scmp_bus_timer.sv
// Request timeout counter: cleared by load, advances while en, flags the
// cycle on which the TIMEOUT-th request cycle is being sampled.
module scmp_bus_timer
   import scmp_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CW = tmr_width(TIMEOUT);

   logic [CW-1:0] count;

   // Count request cycles; cleared while waiting for a strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expire_c = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/scmp_bus_if.sv
// SC/MP bus interface: demultiplexes the address/status phase, turns each
// RD/WR strobe into one req/ack memory transaction and holds the core.
module scmp_bus_if
   import scmp_bus_pkg::*;
#(
   parameter int unsigned      TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CPU_AW-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_d_o,
   input  logic              cpu_ads_n,
   input  logic              cpu_rd_n,
   input  logic              cpu_wr_n,
   output logic [DATA_W-1:0] cpu_d_i,
   output logic              cpu_hold,
   scmp_bus_if_if.master     mem,
   output logic              fetch,
   output logic              delay,
   output logic              halt_pulse,
   output logic              bus_err,
   input  logic              err_clr
);

   bus_state_t state;
   logic       rflag;
   logic       strobes_idle_c;
   logic       ads_cap_c;
   logic       tmr_load_c;
   logic       tmr_en_c;
   logic       tmr_expire_c;

   assign strobes_idle_c = cpu_rd_n & cpu_wr_n;
   // Address capture from IDLE, or straight out of DONE for back-to-back cycles
   assign ads_cap_c      = !cpu_ads_n &&
                           ((state == IDLE) || ((state == DONE) && strobes_idle_c));
   assign tmr_load_c     = (state == ADDR);
   assign tmr_en_c       = (state == REQ);

   scmp_bus_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_c),
      .en       (tmr_en_c),
      .expire_c (tmr_expire_c)
   );

   // Bus cycle FSM with all outputs registered; error sets override err_clr
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rflag      <= 1'b0;
         mem.addr   <= '0;
         mem.wdata  <= '0;
         mem.we     <= 1'b0;
         mem.req    <= 1'b0;
         cpu_hold   <= 1'b0;
         cpu_d_i    <= '0;
         fetch      <= 1'b0;
         delay      <= 1'b0;
         halt_pulse <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         halt_pulse <= 1'b0;
         if (err_clr) begin
            bus_err <= 1'b0;
         end

         if (ads_cap_c) begin
            mem.addr   <= {cpu_d_o[3:0], cpu_addr};
            fetch      <= cpu_d_o[FLG_I];
            delay      <= cpu_d_o[FLG_D];
            rflag      <= cpu_d_o[FLG_R];
            halt_pulse <= cpu_d_o[FLG_H];
            state      <= ADDR;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end

               ADDR: begin
                  if (!cpu_ads_n) begin
                     bus_err <= 1'b1;
                  end
                  if (!cpu_wr_n) begin
                     mem.wdata <= cpu_d_o;
                     mem.we    <= 1'b1;
                     mem.req   <= 1'b1;
                     cpu_hold  <= 1'b1;
                     state     <= REQ;
                     if (!cpu_rd_n || rflag) begin
                        bus_err <= 1'b1;
                     end
                  end else if (!cpu_rd_n) begin
                     mem.we   <= 1'b0;
                     mem.req  <= 1'b1;
                     cpu_hold <= 1'b1;
                     state    <= REQ;
                     if (!rflag) begin
                        bus_err <= 1'b1;
                     end
                  end
               end

               REQ: begin
                  if (!cpu_ads_n) begin
                     bus_err <= 1'b1;
                  end
                  if (mem.ack) begin
                     if (!mem.we) begin
                        cpu_d_i <= mem.rdata;
                     end
                     mem.req  <= 1'b0;
                     cpu_hold <= 1'b0;
                     state    <= DONE;
                  end else if (tmr_expire_c) begin
                     if (!mem.we) begin
                        cpu_d_i <= ERR_DATA;
                     end
                     mem.req  <= 1'b0;
                     cpu_hold <= 1'b0;
                     bus_err  <= 1'b1;
                     state    <= DONE;
                  end
               end

               DONE: begin
                  if (strobes_idle_c) begin
                     state <= IDLE;
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
